cordic_iter_engine: RTL

//  Iterative, folded CORDIC engine. Unrolls ITERS_PER_CYCLE micro-rotations per clock over ITERATIONS total.
//  Per transaction it runs in rotation mode (cos/sin of an angle) or vectoring mode (magnitude/atan of x,y).

---
 rtl/cordic_iter_engine_if.sv | 28 ++
 rtl/cordic_iter_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_engine_if.sv
// Handshake bundle for the folded CORDIC engine.
// The requester/consumer side uses the master modport. The engine uses the slave modport.
interface cordic_iter_engine_if #(
  parameter int WIDTH = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;
  logic                    busy;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, busy
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, busy
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// Folded CORDIC engine. It applies ITERS_PER_CYCLE micro-rotations per enabled clock.
// Over ITERATIONS micro-rotations it computes one of two results:
//   rotation mode (cos/sin of in_z), or
//   vectoring mode (gain-scaled magnitude and atan of in_x/in_y).
module cordic_iter_engine #(
  parameter int FRACS           = 21,
  parameter int INTS            = 1,
  parameter int ITERATIONS      = 16,
  parameter int ITERS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_en,
  cordic_iter_engine_if.slave  bus
);

  localparam int WIDTH  = INTS + FRACS + 1;
  localparam int N      = ITERATIONS / ITERS_PER_CYCLE;
  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  localparam int IW     = 5;  // covers micro-rotation indices 0..23
  localparam int RND_SH = 30 - FRACS;
  localparam logic [31:0] RND_HALF = (32'd1 << RND_SH) >> 1;

  // Rotation starts from x = 1/An so that the CORDIC gain cancels and out_x/out_y are plain cos/sin.
  localparam logic signed [WIDTH-1:0] KINV =
    WIDTH'($rtoi(0.607252935 * (2.0 ** FRACS) + 0.5));

  // Reject parameter sets the datapath cannot represent.
  generate
    if (ITERATIONS < 1 || ITERATIONS > 24) begin : g_bad_iterations
      $error("cordic_iter_engine: ITERATIONS must be in 1..24");
    end
    if (ITERS_PER_CYCLE < 1 || (ITERATIONS % ITERS_PER_CYCLE) != 0) begin : g_bad_unroll
      $error("cordic_iter_engine: ITERS_PER_CYCLE must divide ITERATIONS");
    end
    if (FRACS < 1 || FRACS > 30) begin : g_bad_fracs
      $error("cordic_iter_engine: FRACS must be in 1..30");
    end
  endgenerate

  // atan(2^-i) is stored with 30 fractional bits.
  // The value is rounded to FRACS bits here. The index is a runtime signal, so this builds a small constant mux.
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [IW-1:0] i);
    logic [31:0] a30;
    logic [31:0] r;
    case (i)
      5'd0:    a30 = 32'd843314857;
      5'd1:    a30 = 32'd497837829;
      5'd2:    a30 = 32'd263043837;
      5'd3:    a30 = 32'd133525159;
      5'd4:    a30 = 32'd67021687;
      5'd5:    a30 = 32'd33543516;
      5'd6:    a30 = 32'd16775851;
      5'd7:    a30 = 32'd8388437;
      5'd8:    a30 = 32'd4194283;
      5'd9:    a30 = 32'd2097149;
      5'd10:   a30 = 32'd1048576;
      5'd11:   a30 = 32'd524288;
      5'd12:   a30 = 32'd262144;
      5'd13:   a30 = 32'd131072;
      5'd14:   a30 = 32'd65536;
      5'd15:   a30 = 32'd32768;
      5'd16:   a30 = 32'd16384;
      5'd17:   a30 = 32'd8192;
      5'd18:   a30 = 32'd4096;
      5'd19:   a30 = 32'd2048;
      5'd20:   a30 = 32'd1024;
      5'd21:   a30 = 32'd512;
      5'd22:   a30 = 32'd256;
      5'd23:   a30 = 32'd128;
      default: a30 = 32'd0;
    endcase
    r = (a30 + RND_HALF) >> RND_SH;
    return WIDTH'(r);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    mode_reg, mode_next;
  logic signed [WIDTH-1:0] x_reg, y_reg, z_reg;
  logic signed [WIDTH-1:0] x_next, y_next, z_next;
  logic signed [WIDTH-1:0] x_step, y_step, z_step;
  logic                    last_step;
  logic                    load_en;
  logic                    step_en;
  logic                    in_ready_int;
  logic                    busy_int;
  logic                    out_valid_int;

  assign last_step = (cnt_reg == CW'(N - 1));

  // Unrolled micro-rotation chain.
  // Stage gi applies iteration cnt*ITERS_PER_CYCLE+gi to the output of the previous stage.
  genvar gi;
  generate
    for (gi = 0; gi < ITERS_PER_CYCLE; gi++) begin : g_stage
      logic signed [WIDTH-1:0] x_i, y_i, z_i;
      logic signed [WIDTH-1:0] x_o, y_o, z_o;
      logic signed [WIDTH-1:0] x_sh, y_sh, ang;
      logic [IW-1:0]           idx;
      logic                    d_pos;

      if (gi == 0) begin : g_head
        assign x_i = x_reg;
        assign y_i = y_reg;
        assign z_i = z_reg;
      end else begin : g_link
        assign x_i = g_stage[gi-1].x_o;
        assign y_i = g_stage[gi-1].y_o;
        assign z_i = g_stage[gi-1].z_o;
      end

      assign idx  = IW'(cnt_reg) * IW'(ITERS_PER_CYCLE) + IW'(gi);
      // Rotation drives z toward zero. Vectoring drives y toward zero.
      assign d_pos = mode_reg ? y_i[WIDTH-1] : ~z_i[WIDTH-1];
      assign x_sh  = x_i >>> idx;
      assign y_sh  = y_i >>> idx;
      assign ang   = atan_lut(idx);
      assign x_o   = d_pos ? (x_i - y_sh) : (x_i + y_sh);
      assign y_o   = d_pos ? (y_i + x_sh) : (y_i - x_sh);
      assign z_o   = d_pos ? (z_i - ang)  : (z_i + ang);
    end
  endgenerate

  assign x_step = g_stage[ITERS_PER_CYCLE-1].x_o;
  assign y_step = g_stage[ITERS_PER_CYCLE-1].y_o;
  assign z_step = g_stage[ITERS_PER_CYCLE-1].z_o;

  // State register: reset aborts any transaction in flight, and clk_en low freezes the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept, iterate N cycles, then hold the result until it is consumed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) state_next = S_BUSY;
      end
      S_BUSY: begin
        if (last_step) state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_next = bus.in_valid ? S_BUSY : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs and datapath enables.
  // In DONE a consumed result frees the engine in the same cycle, which allows back-to-back requests.
  always_comb begin
    in_ready_int  = 1'b0;
    busy_int      = 1'b0;
    out_valid_int = 1'b0;
    load_en       = 1'b0;
    step_en       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready_int = 1'b1;
        load_en      = bus.in_valid;
      end
      S_BUSY: begin
        busy_int = 1'b1;
        step_en  = 1'b1;
      end
      S_DONE: begin
        out_valid_int = 1'b1;
        in_ready_int  = bus.out_ready;
        load_en       = bus.out_ready & bus.in_valid;
      end
      default: ;
    endcase
  end

  // Datapath next values: load a new request, or advance one folded step.
  always_comb begin
    x_next    = x_reg;
    y_next    = y_reg;
    z_next    = z_reg;
    mode_next = mode_reg;
    cnt_next  = cnt_reg;
    if (load_en) begin
      mode_next = bus.in_mode;
      cnt_next  = '0;
      if (bus.in_mode) begin
        x_next = bus.in_x;
        y_next = bus.in_y;
        z_next = '0;
      end else begin
        x_next = KINV;
        y_next = '0;
        z_next = bus.in_z;
      end
    end else if (step_en) begin
      x_next   = x_step;
      y_next   = y_step;
      z_next   = z_step;
      cnt_next = last_step ? '0 : cnt_reg + CW'(1);
    end
  end

  // Datapath registers: cleared by reset and held while clk_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
      mode_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (clk_en) begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      z_reg    <= z_next;
      mode_reg <= mode_next;
      cnt_reg  <= cnt_next;
    end
  end

  // While reset is asserted, the engine must not advertise that it can accept a request.
  assign bus.in_ready  = in_ready_int & reset_n;
  assign bus.busy      = busy_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_x     = x_reg;
  assign bus.out_y     = y_reg;
  assign bus.out_z     = z_reg;

endmodule
